// File: rtl/ram_bus_arbiter.sv
// Two-master round-robin front end for a single-port synchronous RAM.
// One access per transaction, fixed IDLE->ACCESS->CAPTURE->DONE sequence.
module ram_bus_arbiter #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_done,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_done,
    output logic [DW-1:0] m1_rdata,
    output logic          busy,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state_q;
    logic          rr_q;     // 1: master 1 wins a tie
    logic          owner_q;  // master currently holding the bus
    logic          m0_gnt_q;
    logic          m1_gnt_q;
    logic          m0_done_q;
    logic          m1_done_q;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;
    logic          busy_q;
    logic          ram_cen_q;
    logic          ram_wen_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_din_q;

    logic          win_vld_d;
    logic          win_sel_d;
    logic          win_we_d;
    logic [AW-1:0] win_addr_d;
    logic [DW-1:0] win_wdata_d;

    always_comb begin
        win_vld_d   = m0_req | m1_req;
        win_sel_d   = (m0_req & m1_req) ? rr_q : m1_req;
        win_we_d    = win_sel_d ? m1_we    : m0_we;
        win_addr_d  = win_sel_d ? m1_addr  : m0_addr;
        win_wdata_d = win_sel_d ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            owner_q    <= 1'b0;
            m0_gnt_q   <= 1'b0;
            m1_gnt_q   <= 1'b0;
            m0_done_q  <= 1'b0;
            m1_done_q  <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            busy_q     <= 1'b0;
            ram_cen_q  <= 1'b0;
            ram_wen_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        ram_cen_q  <= 1'b1;
                        ram_wen_q  <= win_we_d;
                        ram_addr_q <= win_addr_d;
                        ram_din_q  <= win_wdata_d;
                        m0_gnt_q   <= ~win_sel_d;
                        m1_gnt_q   <= win_sel_d;
                        owner_q    <= win_sel_d;
                        rr_q       <= ~win_sel_d;
                        busy_q     <= 1'b1;
                        state_q    <= ACCESS;
                    end else begin
                        ram_cen_q  <= 1'b0;
                        ram_wen_q  <= 1'b0;
                        ram_addr_q <= '0;
                        ram_din_q  <= '0;
                    end
                end
                // The RAM samples cen/wen/addr/din on this edge
                ACCESS: begin
                    ram_cen_q <= 1'b0;
                    ram_wen_q <= 1'b0;
                    state_q   <= CAPTURE;
                end
                CAPTURE: begin
                    if (owner_q) begin
                        m1_rdata_q <= ram_dout;
                        m1_done_q  <= 1'b1;
                    end else begin
                        m0_rdata_q <= ram_dout;
                        m0_done_q  <= 1'b1;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    m0_done_q  <= 1'b0;
                    m1_done_q  <= 1'b0;
                    m0_gnt_q   <= 1'b0;
                    m1_gnt_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    ram_addr_q <= '0;
                    ram_din_q  <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_gnt   = m0_gnt_q;
    assign m1_gnt   = m1_gnt_q;
    assign m0_done  = m0_done_q;
    assign m1_done  = m1_done_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign busy     = busy_q;
    assign ram_cen  = ram_cen_q;
    assign ram_wen  = ram_wen_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule
